row_scan_decoder: RTL and testbench
===================================

ROW_SCAN_DECODER -- requirements
Module: row_scan_decoder

Interface
REQ-001 Parameter SEL_WIDTH, default 2: select width; decoder drives NUM_LINES = 2**SEL_WIDTH lines; legal range 1..6.
REQ-002 Parameter DWELL_CYCLES, default 4: cycles each line is held active in scan mode; legal range >= 1.
REQ-003 Parameter BLANK_CYCLES, default 1: all-lines-off cycles before each line in scan mode; legal range >= 0.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = drive lines; 0 = all lines off.
REQ-007 mode  input  1  0 = DIRECT (host-selected line), 1 = SCAN (auto-sequenced lines).
REQ-008 sel_in  input  SEL_WIDTH  line index offered in DIRECT mode.
REQ-009 sel_valid  input  1  sel_in valid; transfer when sel_valid and sel_ready both high.
REQ-010 sel_ready  output  1  high only in state DIRECT.
REQ-011 line_out  output  NUM_LINES  registered one-hot (or all-zero) line drive.
REQ-012 cur_sel  output  SEL_WIDTH  registered index of the current/last active line.
REQ-013 frame_done  output  1  one-cycle pulse at end of each scan frame.
REQ-014 busy  output  1  high in SCAN_BLANK and SCAN_ON.

Function
REQ-015 FSM states: IDLE, DIRECT, SCAN_BLANK, SCAN_ON.
REQ-016 IDLE: line_out = 0; enable=1 and mode=0 -> DIRECT; enable=1 and mode=1 -> scan start (REQ-020).
REQ-017 Any state with enable=0 -> IDLE next cycle; line_out = 0 and frame_done = 0 from that cycle; cur_sel holds.
REQ-018 DIRECT: on transfer, cur_sel <= sel_in and line_out <= one-hot(sel_in) next cycle (latency 1); without transfer, outputs hold.
REQ-019 DIRECT entry from IDLE: line_out = 0 until first transfer.
REQ-020 Scan start (from IDLE, or from DIRECT when mode=1): cur_sel <= 0, dwell/blank counter cleared; next state SCAN_BLANK if BLANK_CYCLES > 0, else SCAN_ON.
REQ-021 SCAN_BLANK: line_out = 0 for exactly BLANK_CYCLES cycles, then SCAN_ON.
REQ-022 SCAN_ON: line_out = one-hot(cur_sel) for exactly DWELL_CYCLES cycles.
REQ-023 End of dwell with cur_sel < NUM_LINES-1: cur_sel increments, re-enter SCAN_BLANK (or SCAN_ON if BLANK_CYCLES = 0).
REQ-024 End of dwell with cur_sel = NUM_LINES-1: frame_done high that cycle; cur_sel wraps to 0; if mode=0 -> DIRECT (line_out = 0 next cycle), else next frame.
REQ-025 mode change 1->0 mid-frame takes effect only at frame end (REQ-024); mode change 0->1 takes effect the next cycle.
REQ-026 Frame length = NUM_LINES * (BLANK_CYCLES + DWELL_CYCLES) cycles.
REQ-027 line_out never has more than one bit set in any cycle.
REQ-028 sel_valid and sel_in ignored outside DIRECT; no transfer occurs while sel_ready = 0.
REQ-029 Counter width: $clog2 of max(DWELL_CYCLES, BLANK_CYCLES, 2); no overflow for legal parameters.

Reset
REQ-030 reset asserted: state IDLE, line_out = 0, cur_sel = 0, frame_done = 0, busy = 0, counter = 0, immediately and independent of clk.
REQ-031 reset mid-frame aborts scan; after release, behaviour restarts from IDLE per REQ-016.

Structure
REQ-032 Shared package decoder_pkg holds the FSM state enum and the MODE_DIRECT/MODE_SCAN constants.
REQ-033 Index-to-one-hot conversion is a parametrised combinational sub-module onehot_decoder (SEL_WIDTH in, 2**SEL_WIDTH out).
REQ-034 All outputs are driven from registers; no combinational path from inputs to line_out.

Verification (SEL_WIDTH=2, DWELL_CYCLES=3, BLANK_CYCLES=1 unless stated)
REQ-035 Reset then enable=1, mode=0, sel_in=2 with sel_valid=1 -> line_out=4'b0100, cur_sel=2 one cycle after transfer.
REQ-036 enable=1, mode=1 from IDLE -> pattern 0000, 0001x3, 0000, 0010x3, 0000, 0100x3, 0000, 1000x3; frame_done high only on 16th cycle; repeats.
REQ-037 mode 1->0 during line 1 of scan -> scan completes through line 3, frame_done pulses, then DIRECT with line_out=0 and sel_ready=1.
REQ-038 enable dropped during SCAN_ON of line 2 -> line_out=0 and busy=0 next cycle; cur_sel stays 2.
REQ-039 reset asserted asynchronously mid-dwell -> all outputs zero before next clk edge; BLANK_CYCLES=0 run gives back-to-back 0001x3, 0010x3 with no zero cycles.
REQ-040 Every cycle of every scenario: popcount(line_out) <= 1.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the row scan decoder.
package decoder_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DIRECT     = 2'd1,
      ST_SCAN_BLANK = 2'd2,
      ST_SCAN_ON    = 2'd3
   } state_e;

   // Encoding of the mode input
   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Largest of three values
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Width of the shared dwell/blank counter; never below one bit
   function automatic int unsigned cnt_width(input int unsigned dwell,
                                             input int unsigned blank);
      return $clog2(max3(dwell, blank, 2));
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index to one-hot conversion.
module onehot_decoder #(
   parameter int SEL_WIDTH = 2
) (
   input  logic [SEL_WIDTH-1:0]    sel,
   output logic [2**SEL_WIDTH-1:0] onehot
);

   // Set exactly the bit addressed by sel
   always_comb begin
      // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
      onehot      = '0;
      onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/row_scan_decoder.sv
// Row line decoder with host-selected (DIRECT) and auto-sequenced (SCAN) modes.
// Every output comes straight from a flop; next values are computed one cycle ahead.
module row_scan_decoder
   import decoder_pkg::*;
#(
   parameter int SEL_WIDTH    = 2,
   parameter int DWELL_CYCLES = 4,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    mode,
   input  logic [SEL_WIDTH-1:0]    sel_in,
   input  logic                    sel_valid,
   output logic                    sel_ready,
   output logic [2**SEL_WIDTH-1:0] line_out,
   output logic [SEL_WIDTH-1:0]    cur_sel,
   output logic                    frame_done,
   output logic                    busy
);

   localparam int NUM_LINES = 2**SEL_WIDTH;
   localparam int CNT_W     = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
   localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

   localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0]     BLANK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
   localparam logic [SEL_WIDTH-1:0] SEL_LAST   = SEL_WIDTH'(NUM_LINES - 1);

   // First state of every line slot in scan mode
   localparam state_e SLOT_ENTRY = HAS_BLANK ? ST_SCAN_BLANK : ST_SCAN_ON;

   state_e                 state_q,      state_d;
   logic [CNT_W-1:0]       cnt_q,        cnt_d;
   logic [SEL_WIDTH-1:0]   cur_sel_q,    cur_sel_d;
   logic [NUM_LINES-1:0]   line_q,       line_d;
   logic                   frame_done_q, frame_done_d;
   logic                   busy_q,       busy_d;
   logic                   sel_ready_q,  sel_ready_d;

   logic                   transfer;
   logic                   scan_start;
   logic [NUM_LINES-1:0]   next_onehot;

   // Next state, counter and line index
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_sel_d  = cur_sel_q;
      transfer   = 1'b0;
      scan_start = 1'b0;

      if (!enable) begin
         // Dropping enable aborts whatever is running; the index is kept.
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (mode == MODE_SCAN) scan_start = 1'b1;
               else                   state_d    = ST_DIRECT;
            end

            ST_DIRECT: begin
               // A switch to scan wins over a simultaneous host transfer.
               if (mode == MODE_SCAN) begin
                  scan_start = 1'b1;
               end else if (sel_valid && sel_ready_q) begin
                  transfer  = 1'b1;
                  cur_sel_d = sel_in;
               end
            end

            ST_SCAN_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_SCAN_ON;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            ST_SCAN_ON: begin
               if (cnt_q == DWELL_LAST) begin
                  cnt_d = '0;
                  if (cur_sel_q != SEL_LAST) begin
                     cur_sel_d = cur_sel_q + 1'b1;
                     state_d   = SLOT_ENTRY;
                  end else begin
                     // End of frame: the only point where scan returns to direct mode.
                     cur_sel_d = '0;
                     state_d   = (mode == MODE_SCAN) ? SLOT_ENTRY : ST_DIRECT;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            default: state_d = ST_IDLE;
         endcase

         if (scan_start) begin
            state_d   = SLOT_ENTRY;
            cur_sel_d = '0;
            cnt_d     = '0;
         end
      end
   end

   // Decode the index that will be current next cycle
   onehot_decoder #(
      .SEL_WIDTH (SEL_WIDTH)
   ) u_onehot (
      .sel    (cur_sel_d),
      .onehot (next_onehot)
   );

   // Next registered outputs, derived from the next state
   always_comb begin
      unique case (state_d)
         ST_SCAN_ON: line_d = next_onehot;
         // Lines stay dark on entry to direct mode until the first transfer.
         ST_DIRECT:  line_d = transfer ? next_onehot
                                       : ((state_q == ST_DIRECT) ? line_q : '0);
         default:    line_d = '0;
      endcase

      // Raised one cycle early so the flop shows it during the final dwell cycle.
      frame_done_d = (state_d == ST_SCAN_ON) && (cnt_d == DWELL_LAST) &&
                     (cur_sel_d == SEL_LAST);
      busy_d       = (state_d == ST_SCAN_BLANK) || (state_d == ST_SCAN_ON);
      sel_ready_d  = (state_d == ST_DIRECT);
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cur_sel_q    <= '0;
         line_q       <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         sel_ready_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_sel_q    <= cur_sel_d;
         line_q       <= line_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         sel_ready_q  <= sel_ready_d;
      end
   end

   assign line_out   = line_q;
   assign cur_sel    = cur_sel_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;
   assign sel_ready  = sel_ready_q;

endmodule

// File: tb/tb_row_scan_decoder.sv
// Directed bench for row_scan_decoder: one instance with a blank slot, one without.
module tb_row_scan_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: SEL_WIDTH=2, DWELL_CYCLES=3, BLANK_CYCLES=1
   logic       reset, enable, mode, sel_valid;
   logic [1:0] sel_in;
   logic       sel_ready, frame_done, busy;
   logic [3:0] line_out;
   logic [1:0] cur_sel;

   // Instance B: SEL_WIDTH=2, DWELL_CYCLES=3, BLANK_CYCLES=0
   logic       reset_b, enable_b, mode_b, sel_valid_b;
   logic [1:0] sel_in_b;
   logic       sel_ready_b, frame_done_b, busy_b;
   logic [3:0] line_out_b;
   logic [1:0] cur_sel_b;

   int errors = 0;
   int checks = 0;

   // Expected line drive for cycles 1..16 of a frame on instance A
   logic [3:0] pat_a [16] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001,
                              4'b0000, 4'b0010, 4'b0010, 4'b0010,
                              4'b0000, 4'b0100, 4'b0100, 4'b0100,
                              4'b0000, 4'b1000, 4'b1000, 4'b1000};
   // Expected line drive for cycles 1..12 of a frame on instance B
   logic [3:0] pat_b [12] = '{4'b0001, 4'b0001, 4'b0001,
                              4'b0010, 4'b0010, 4'b0010,
                              4'b0100, 4'b0100, 4'b0100,
                              4'b1000, 4'b1000, 4'b1000};

   row_scan_decoder #(.SEL_WIDTH(2), .DWELL_CYCLES(3), .BLANK_CYCLES(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .mode       (mode),
      .sel_in     (sel_in),
      .sel_valid  (sel_valid),
      .sel_ready  (sel_ready),
      .line_out   (line_out),
      .cur_sel    (cur_sel),
      .frame_done (frame_done),
      .busy       (busy)
   );

   row_scan_decoder #(.SEL_WIDTH(2), .DWELL_CYCLES(3), .BLANK_CYCLES(0)) dut_b (
      .clk        (clk),
      .reset      (reset_b),
      .enable     (enable_b),
      .mode       (mode_b),
      .sel_in     (sel_in_b),
      .sel_valid  (sel_valid_b),
      .sel_ready  (sel_ready_b),
      .line_out   (line_out_b),
      .cur_sel    (cur_sel_b),
      .frame_done (frame_done_b),
      .busy       (busy_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock, then sample; line_out of both instances must never be multi-hot
   task automatic tick();
      @(posedge clk);
      #1;
      check("onehot_a", 32'($countones(line_out) <= 1), 32'd1);
      check("onehot_b", 32'($countones(line_out_b) <= 1), 32'd1);
   endtask

   // Compare instance A against cycle k (1..16) of a scan frame
   task automatic scan_cycle(input int k);
      check($sformatf("scan_line_c%0d", k),  32'(line_out),   32'(pat_a[k-1]));
      check($sformatf("scan_sel_c%0d", k),   32'(cur_sel),    32'((k - 1) / 4));
      check($sformatf("scan_done_c%0d", k),  32'(frame_done), 32'(k == 16));
      check($sformatf("scan_busy_c%0d", k),  32'(busy),       32'd1);
      check($sformatf("scan_ready_c%0d", k), 32'(sel_ready),  32'd0);
   endtask

   initial begin
      reset = 1'b1;  enable = 1'b0;  mode = 1'b0;  sel_in = 2'd0;  sel_valid = 1'b0;
      reset_b = 1'b1; enable_b = 1'b0; mode_b = 1'b0; sel_in_b = 2'd0; sel_valid_b = 1'b0;

      // Reset state
      tick();
      check("rst_line",  32'(line_out),   32'd0);
      check("rst_sel",   32'(cur_sel),    32'd0);
      check("rst_done",  32'(frame_done), 32'd0);
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_ready", 32'(sel_ready),  32'd0);
      reset = 1'b0; reset_b = 1'b0;

      // Direct mode: dark on entry, latency-1 transfer, hold without valid
      enable = 1'b1; mode = 1'b0;
      tick();
      check("dir_entry_ready", 32'(sel_ready), 32'd1);
      check("dir_entry_line",  32'(line_out),  32'd0);
      check("dir_entry_busy",  32'(busy),      32'd0);
      sel_in = 2'd2; sel_valid = 1'b1;
      tick();
      check("dir_xfer2_line", 32'(line_out), 32'b0100);
      check("dir_xfer2_sel",  32'(cur_sel),  32'd2);
      sel_valid = 1'b0; sel_in = 2'd3;
      tick();
      check("dir_hold_line", 32'(line_out), 32'b0100);
      check("dir_hold_sel",  32'(cur_sel),  32'd2);
      sel_in = 2'd1; sel_valid = 1'b1;
      tick();
      check("dir_xfer1_line", 32'(line_out), 32'b0010);
      check("dir_xfer1_sel",  32'(cur_sel),  32'd1);
      sel_valid = 1'b0;

      // Enable low: lines off, index held
      enable = 1'b0;
      tick();
      check("off_line",  32'(line_out),  32'd0);
      check("off_ready", 32'(sel_ready), 32'd0);
      check("off_sel",   32'(cur_sel),   32'd1);

      // Scan from idle: two full frames; host inputs are ignored meanwhile
      sel_in = 2'd3; sel_valid = 1'b1;
      enable = 1'b1; mode = 1'b1;
      for (int f = 0; f < 2; f++) begin
         for (int k = 1; k <= 16; k++) begin
            tick();
            scan_cycle(k);
         end
      end
      sel_valid = 1'b0;

      // Mode drops to direct during line 1: frame still completes
      for (int k = 1; k <= 6; k++) begin
         tick();
         scan_cycle(k);
      end
      mode = 1'b0;
      for (int k = 7; k <= 16; k++) begin
         tick();
         scan_cycle(k);
      end
      tick();
      check("exit_line",  32'(line_out),   32'd0);
      check("exit_ready", 32'(sel_ready),  32'd1);
      check("exit_busy",  32'(busy),       32'd0);
      check("exit_done",  32'(frame_done), 32'd0);
      check("exit_sel",   32'(cur_sel),    32'd0);

      // Direct to scan takes effect next cycle; then enable drops on line 2
      mode = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         scan_cycle(k);
      end
      enable = 1'b0;
      tick();
      check("abort_line", 32'(line_out),   32'd0);
      check("abort_busy", 32'(busy),       32'd0);
      check("abort_sel",  32'(cur_sel),    32'd2);
      check("abort_done", 32'(frame_done), 32'd0);

      // Asynchronous reset mid-dwell of line 0
      enable = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         scan_cycle(k);
      end
      #3 reset = 1'b1;
      #1;
      check("arst_line",  32'(line_out),   32'd0);
      check("arst_sel",   32'(cur_sel),    32'd0);
      check("arst_busy",  32'(busy),       32'd0);
      check("arst_done",  32'(frame_done), 32'd0);
      check("arst_ready", 32'(sel_ready),  32'd0);
      tick();
      check("arst_hold_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();
      scan_cycle(1);
      tick();
      scan_cycle(2);

      // No blank slots: back-to-back dwells, frame_done on cycle 12
      enable_b = 1'b1; mode_b = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         check($sformatf("nb_line_c%0d", k), 32'(line_out_b),   32'(pat_b[(k - 1) % 12]));
         check($sformatf("nb_done_c%0d", k), 32'(frame_done_b), 32'(k == 12));
         check($sformatf("nb_busy_c%0d", k), 32'(busy_b),       32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
